// File: rtl/a_channel_driver.sv
// a_channel_driver: self-sequencing multi-beat A-channel stimulus source with watchdog
module a_channel_driver #(
  parameter int OPCODE_W       = 4,
  parameter int BEAT_W         = 2,
  parameter int DATA_W         = 8,
  parameter int NUM_BEATS      = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int OPCODE_MODE    = 1,
  parameter int BASE_OPCODE    = 4,
  parameter int DATA_SEED      = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         cfg_max_txns,
  input  logic                a_ready,
  output logic                a_valid,
  output logic [OPCODE_W-1:0] a_opcode,
  output logic [BEAT_W-1:0]   a_beat,
  output logic [DATA_W-1:0]   a_data,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [15:0]         txn_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t              state_q;
  logic [15:0]         max_q, txn_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [OPCODE_W-1:0] op_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q, busy_q, done_q, to_q;
  logic [31:0]         wd_q, gap_q;
  logic                xfer, last, expire;
  logic [15:0]         txn_d;
  function automatic logic [DATA_W-1:0] data_f(input logic [15:0] t, input logic [BEAT_W-1:0] b);
    return DATA_W'(32'(t) * 32'(NUM_BEATS) + 32'(b)) ^ DATA_W'(DATA_SEED);
  endfunction
  function automatic logic [OPCODE_W-1:0] op_f(input logic [15:0] t);
    return OPCODE_MODE != 0 ? OPCODE_W'(BASE_OPCODE) + OPCODE_W'(t) : OPCODE_W'(BASE_OPCODE);
  endfunction
  always_comb begin
    xfer   = valid_q && a_ready;
    last   = beat_q == BEAT_W'(NUM_BEATS - 1);
    txn_d  = txn_q + 16'd1;
    expire = TIMEOUT_CYCLES != 0 && wd_q + 32'd1 == 32'(TIMEOUT_CYCLES);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      max_q   <= '0;
      txn_q   <= '0;
      beat_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          max_q  <= cfg_max_txns;
          txn_q  <= '0;
          to_q   <= 1'b0;
          wd_q   <= '0;
          beat_q <= '0;
          op_q   <= op_f(16'd0);
          data_q <= data_f(16'd0, '0);
          if (cfg_max_txns == 16'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= SEND;
            done_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND, GAP: begin
          wd_q <= wd_q + 32'd1;
          if (xfer && last) txn_q <= txn_d;
          // a completing final beat beats a simultaneous watchdog expiry
          if (xfer && last && txn_d == max_q) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (expire) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            to_q    <= 1'b1;
          end else if (state_q == SEND && xfer) begin
            beat_q <= last ? '0 : beat_q + 1'b1;
            op_q   <= last ? op_f(txn_d) : op_q;
            data_q <= last ? data_f(txn_d, '0) : data_f(txn_q, beat_q + 1'b1);
            if (last && GAP_CYCLES > 0) begin
              state_q <= GAP;
              valid_q <= 1'b0;
              gap_q   <= '0;
            end
          end else if (state_q == GAP) begin
            gap_q <= gap_q + 32'd1;
            if (gap_q == 32'(GAP_CYCLES - 1)) begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign a_valid   = valid_q;
  assign a_opcode  = op_q;
  assign a_beat    = beat_q;
  assign a_data    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = to_q;
  assign txn_count = txn_q;
endmodule

// File: tb/tb_a_channel_driver.sv
// tb_a_channel_driver: vector table plus beat scoreboard for three parameterisations of the driver
module tb_a_channel_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic d_start = 0, g_start = 0, s_start = 0;
  logic d_ready = 0, g_ready = 0, s_ready = 0;
  logic [15:0] d_cfg = 0, g_cfg = 0, s_cfg = 0;
  logic d_valid, g_valid, s_valid, d_busy, g_busy, s_busy, d_done, g_done, s_done, d_to, g_to, s_to;
  logic [3:0] d_op, g_op, s_op;
  logic [1:0] d_beat, g_beat, s_beat;
  logic [7:0] d_data, g_data, s_data;
  logic [15:0] d_cnt, g_cnt, s_cnt;

  a_channel_driver u_d (.clk(clk), .reset(reset), .start(d_start), .cfg_max_txns(d_cfg), .a_ready(d_ready),
    .a_valid(d_valid), .a_opcode(d_op), .a_beat(d_beat), .a_data(d_data), .busy(d_busy), .done(d_done),
    .timed_out(d_to), .txn_count(d_cnt));
  a_channel_driver #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(20)) u_g (.clk(clk), .reset(reset), .start(g_start),
    .cfg_max_txns(g_cfg), .a_ready(g_ready), .a_valid(g_valid), .a_opcode(g_op), .a_beat(g_beat), .a_data(g_data),
    .busy(g_busy), .done(g_done), .timed_out(g_to), .txn_count(g_cnt));
  a_channel_driver #(.DATA_SEED(8'hA5), .OPCODE_MODE(0)) u_s (.clk(clk), .reset(reset), .start(s_start),
    .cfg_max_txns(s_cfg), .a_ready(s_ready), .a_valid(s_valid), .a_opcode(s_op), .a_beat(s_beat), .a_data(s_data),
    .busy(s_busy), .done(s_done), .timed_out(s_to), .txn_count(s_cnt));

  int vec_n = 0, miss_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [3:0] op; logic [1:0] beat; logic [7:0] data; } beat_t;
  beat_t dq[$], sq[$];
  function automatic void push_run(input bit to_s, input int n, input bit mode, input logic [7:0] seed);
    beat_t e;
    for (int t = 0; t < n; t++)
      for (int b = 0; b < 4; b++) begin
        e.op = mode ? 4'(4 + t) : 4'd4;
        e.beat = 2'(b);
        e.data = 8'(t * 4 + b) ^ seed;
        if (to_s) sq.push_back(e); else dq.push_back(e);
      end
  endfunction

  beat_t d_prev, s_prev, e_d, e_s;
  bit d_held = 0, s_held = 0;
  always @(negedge clk) begin
    if (reset) d_held = 0;
    else begin
      if (d_valid && d_held) chk("d_hold", {18'd0, d_op, d_beat, d_data}, {18'd0, d_prev});
      if (d_valid && d_ready) begin
        if (dq.size() == 0) chk("d_extra_beat", 32'd1, 32'd0);
        else begin
          e_d = dq.pop_front();
          chk("d_beat_payload", {18'd0, d_op, d_beat, d_data}, {18'd0, e_d});
        end
      end
      d_held = d_valid && !d_ready;
      d_prev = {d_op, d_beat, d_data};
    end
  end
  always @(negedge clk) begin
    if (reset) s_held = 0;
    else begin
      if (s_valid && s_held) chk("s_hold", {18'd0, s_op, s_beat, s_data}, {18'd0, s_prev});
      if (s_valid && s_ready) begin
        if (sq.size() == 0) chk("s_extra_beat", 32'd1, 32'd0);
        else begin
          e_s = sq.pop_front();
          chk("s_beat_payload", {18'd0, s_op, s_beat, s_data}, {18'd0, e_s});
        end
      end
      s_held = s_valid && !s_ready;
      s_prev = {s_op, s_beat, s_data};
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [15:0] max; bit full; int exp_cyc; } vec_t;
  vec_t vt[5];
  int n;

  initial begin
    vt[0] = '{16'd3, 1'b1, 13};
    vt[1] = '{16'd1, 1'b1, 5};
    vt[2] = '{16'd0, 1'b1, 1};
    vt[3] = '{16'd5, 1'b0, -1};
    vt[4] = '{16'd2, 1'b0, -1};
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_outputs", {d_valid, d_op, d_beat, d_data, d_busy, d_done, d_to, d_cnt}, 32'd0);
    chk("rst_outputs_g", {g_valid, g_op, g_beat, g_data, g_busy, g_done, g_to, g_cnt}, 32'd0);
    cyc();
    reset = 0;
    cyc();
    // two back-to-back transactions with the sink always ready
    push_run(0, 2, 1, 8'h00);
    d_ready = 1; d_cfg = 2; d_start = 1;
    cyc();
    d_start = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t1_valid", d_valid, 1);
    end
    @(negedge clk);
    chk("t1_done", {d_done, d_valid, d_to, d_cnt}, {3'b100, 16'd2});
    chk("t1_sb_empty", dq.size(), 0);
    // backpressure while beat 1 is presented
    push_run(0, 1, 1, 8'h00);
    d_cfg = 1; d_start = 1;
    cyc();
    d_start = 0;
    cyc();
    d_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_stall", {d_valid, d_op, d_beat, d_data}, {1'b1, 4'd4, 2'd1, 8'h01});
      cyc();
    end
    d_ready = 1;
    cyc();
    @(negedge clk);
    chk("t2_beat2", {d_valid, d_beat, d_data}, {1'b1, 2'd2, 8'h02});
    n = 0;
    while (!d_done && n < 50) begin cyc(); n++; end
    chk("t2_done", {d_done, d_cnt}, {1'b1, 16'd1});
    // table of runs, some with random backpressure
    foreach (vt[i]) begin
      push_run(0, vt[i].max, 1, 8'h00);
      d_cfg = vt[i].max; d_start = 1;
      cyc();
      d_start = 0;
      n = 0;
      do begin
        n++;
        d_ready = vt[i].full ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        if (d_done) break;
        cyc();
      end while (n < 2000);
      if (vt[i].exp_cyc >= 0) chk("tbl_done_cycle", n, vt[i].exp_cyc);
      chk("tbl_final", {d_done, d_to, d_cnt}, {2'b10, vt[i].max});
      chk("tbl_sb_empty", dq.size(), 0);
      cyc();
    end
    // reset during beat 2 of transaction 0, then a zero-length run
    d_ready = 1; d_cfg = 3; push_run(0, 3, 1, 8'h00); d_start = 1;
    cyc();
    d_start = 0;
    cyc();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    dq.delete();
    @(negedge clk);
    chk("t5_reset_outputs", {d_valid, d_op, d_beat, d_data, d_busy, d_done, d_to, d_cnt}, 32'd0);
    cyc();
    d_cfg = 0; d_start = 1;
    cyc();
    d_start = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_zero_run", {d_done, d_valid, d_busy}, 3'b100);
      cyc();
    end
    // gap instance: three transactions with two idle cycles between them
    g_ready = 1; g_cfg = 3; g_start = 1;
    cyc();
    g_start = 0;
    for (int c = 1; c <= 16; c++) begin
      int idx, t;
      idx = (c - 1) % 6;
      t = (c - 1) / 6;
      @(negedge clk);
      if (idx < 4) chk("gap_beat", {g_valid, g_op, g_beat, g_data}, {1'b1, 4'(4 + t), 2'(idx), 8'(t * 4 + idx)});
      else chk("gap_idle", {g_valid, g_busy}, 2'b01);
      cyc();
    end
    @(negedge clk);
    chk("gap_done", {g_done, g_valid, g_to, g_cnt}, {3'b100, 16'd3});
    cyc();
    // watchdog with a permanently stalled sink
    g_ready = 0; g_cfg = 5; g_start = 1;
    cyc();
    g_start = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1 || c == 20) chk("wd_busy", {g_valid, g_busy, g_done}, 3'b110);
      cyc();
    end
    @(negedge clk);
    chk("wd_expired", {g_done, g_to, g_valid, g_busy, g_cnt}, {4'b1100, 16'd0});
    // seeded fixed-opcode run across the data wrap
    push_run(1, 65, 0, 8'hA5);
    s_ready = 1; s_cfg = 65; s_start = 1;
    cyc();
    s_start = 0;
    repeat (256) cyc();
    @(negedge clk);
    chk("seed_wrap", {s_valid, s_op, s_beat, s_data}, {1'b1, 4'd4, 2'd0, 8'hA5});
    repeat (4) cyc();
    @(negedge clk);
    chk("seed_done", {s_done, s_to, s_cnt}, {2'b10, 16'd65});
    chk("seed_sb_empty", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
